// File: rtl/io_pkg.sv
// io_pkg: shared constants and types for the memory-mapped I/O unit.
//   - register address map (4-bit io_addr)
//   - CTRL register bit positions
//   - timer state enum
package io_pkg;

    localparam logic [3:0] A_OUT0   = 4'd0;
    localparam logic [3:0] A_OUT1   = 4'd1;
    localparam logic [3:0] A_OUT2   = 4'd2;
    localparam logic [3:0] A_OUT3   = 4'd3;
    localparam logic [3:0] A_IN0    = 4'd4;
    localparam logic [3:0] A_IN1    = 4'd5;
    localparam logic [3:0] A_IN2    = 4'd6;
    localparam logic [3:0] A_IN3    = 4'd7;
    localparam logic [3:0] A_RELOAD = 4'd8;
    localparam logic [3:0] A_CTRL   = 4'd9;
    localparam logic [3:0] A_STATUS = 4'd10;
    localparam logic [3:0] A_COUNT  = 4'd11;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;

    typedef enum logic {IDLE, RUN} tmr_state_t;

endpackage

// File: rtl/io_timer.sv
// io_timer: programmable down-count timer with level interrupt.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   reload_we    - write strobe for RELOAD
//   ctrl_we      - write strobe for CTRL (EN=1 loads COUNT and (re)starts)
//   wdata        - CPU write data
//   clr          - clear pending (irq_ack or STATUS bit0 write)
//   reload       - RELOAD register
//   ctrl         - CTRL register {AUTO, EN}
//   count        - current COUNT
//   pending      - interrupt pending flag
module io_timer
    import io_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reload_we,
    input  logic              ctrl_we,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr,
    output logic [DATA_W-1:0] reload,
    output logic [1:0]        ctrl,
    output logic [DATA_W-1:0] count,
    output logic              pending
);

    tmr_state_t        state, state_nx;
    logic [DATA_W-1:0] reload_nx, count_nx;
    logic [1:0]        ctrl_nx;
    logic              pending_nx;
    logic              expire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            reload  <= '0;
            ctrl    <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_nx;
            reload  <= reload_nx;
            ctrl    <= ctrl_nx;
            count   <= count_nx;
            pending <= pending_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        reload_nx = reload;
        ctrl_nx   = ctrl;
        count_nx  = count;
        expire    = (state == RUN) && (count == '0);

        if (reload_we) reload_nx = wdata;

        if (state == RUN) begin
            if (expire) begin
                // reload uses the pre-write RELOAD, so a same-cycle RELOAD write
                // only affects the following load
                if (ctrl[CTRL_AUTO]) begin
                    count_nx = reload;
                end else begin
                    count_nx         = '0;
                    ctrl_nx[CTRL_EN] = 1'b0;
                    state_nx         = IDLE;
                end
            end else begin
                count_nx = count - DATA_W'(1);
            end
        end

        // CTRL write overrides the running sequence; EN=0 freezes COUNT
        if (ctrl_we) begin
            ctrl_nx = {wdata[CTRL_AUTO], wdata[CTRL_EN]};
            if (wdata[CTRL_EN]) begin
                count_nx = reload;
                state_nx = RUN;
            end else begin
                count_nx = count;
                state_nx = IDLE;
            end
        end

        // set beats clear when both happen in one cycle
        pending_nx = expire | (pending & ~clr);
    end

endmodule

// File: rtl/io_unit.sv
// io_unit: memory-mapped I/O slave with output ports, synchronised input
// ports and a down-count timer.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   io_addr     - register select
//   io_wdata    - write data
//   io_we/io_re - one-cycle write / read strobes
//   io_rdata    - registered read data (held until next read)
//   io_rvalid   - one-cycle pulse, one cycle after io_re
//   in_ports    - asynchronous inputs, port i at [i*DATA_W +: DATA_W]
//   out_ports   - output port registers, same packing
//   tmr_irq     - timer interrupt pending (level)
//   irq_ack     - clears the pending interrupt
module io_unit
    import io_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NPORTS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               io_addr,
    input  logic [DATA_W-1:0]        io_wdata,
    input  logic                     io_we,
    input  logic                     io_re,
    output logic [DATA_W-1:0]        io_rdata,
    output logic                     io_rvalid,
    input  logic [NPORTS*DATA_W-1:0] in_ports,
    output logic [NPORTS*DATA_W-1:0] out_ports,
    output logic                     tmr_irq,
    input  logic                     irq_ack
);

    logic [NPORTS-1:0][DATA_W-1:0] out_q, sync1, sync2;
    logic [DATA_W-1:0]             reload, count, rd_mux;
    logic [1:0]                    ctrl;
    logic                          pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_ports;
            sync2 <= sync1;
            if (io_we && io_addr[3:2] == 2'b00) out_q[io_addr[1:0]] <= io_wdata;
        end
    end

    assign out_ports = out_q;

    io_timer #(.DATA_W(DATA_W)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .reload_we (io_we && io_addr == A_RELOAD),
        .ctrl_we   (io_we && io_addr == A_CTRL),
        .wdata     (io_wdata),
        .clr       (irq_ack || (io_we && io_addr == A_STATUS && io_wdata[0])),
        .reload    (reload),
        .ctrl      (ctrl),
        .count     (count),
        .pending   (pending)
    );

    assign tmr_irq = pending;

    // mux reads current register state, so a same-cycle write is not seen
    always_comb begin
        rd_mux = '0;
        case (io_addr)
            A_OUT0, A_OUT1, A_OUT2, A_OUT3: rd_mux = out_q[io_addr[1:0]];
            A_IN0, A_IN1, A_IN2, A_IN3:     rd_mux = sync2[io_addr[1:0]];
            A_RELOAD:                       rd_mux = reload;
            A_CTRL:                         rd_mux = {{(DATA_W-2){1'b0}}, ctrl};
            A_STATUS:                       rd_mux = {{(DATA_W-1){1'b0}}, pending};
            A_COUNT:                        rd_mux = count;
            default:                        rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            io_rdata  <= '0;
            io_rvalid <= 1'b0;
        end else begin
            io_rvalid <= io_re;
            if (io_re) io_rdata <= rd_mux;
        end
    end

endmodule

// File: doc/io_unit.md
Name: io_unit

Overview:
- Memory-mapped I/O slave that hangs off the CPU datapath's data/address bus as the downstream consumer of its port accesses.
- Holds four output port registers and samples four external input ports through 2-flop synchronisers.
- Contains a programmable down-count timer that raises a level interrupt toward the control unit.
- One clock domain; the CPU sees registered read data one cycle after a read strobe.

Parameters:
- DATA_W, 16, width of bus data, port registers, timer reload and count.
- NPORTS, 4, number of output ports and number of input ports (fixed at 4 by the address map).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- io_addr  in  4  register select (map below).
- io_wdata  in  DATA_W  write data from CPU.
- io_we  in  1  write strobe, one cycle per write.
- io_re  in  1  read strobe, one cycle per read.
- io_rdata  out  DATA_W  registered read data.
- io_rvalid  out  1  high exactly one cycle after each io_re.
- in_ports  in  NPORTS*DATA_W  asynchronous external inputs; port i is bits [i*DATA_W +: DATA_W].
- out_ports  out  NPORTS*DATA_W  output port registers, packed the same way.
- tmr_irq  out  1  timer interrupt pending (level).
- irq_ack  in  1  clears pending interrupt.

Behaviour:
- Reset: out_ports=0, sync flops=0, RELOAD=0, CTRL=0, COUNT=0, pending=0, io_rdata=0, io_rvalid=0.
- Reset mid-count or mid-read aborts everything; no rvalid is emitted for a read strobed in the reset cycle.
- Address map:
  - 0-3: OUTn, R/W.
  - 4-7: INn, RO, synchronised value.
  - 8: RELOAD, R/W.
  - 9: CTRL, R/W; bit0 EN, bit1 AUTO, upper bits read 0.
  - 10: STATUS; read gives {0…, pending}; writing bit0=1 clears pending.
  - 11: COUNT, RO.
  - 12-15: read 0.
- Writes to RO or unused addresses are ignored.
- Write: on a cycle with io_we=1, the target register updates at that clock edge and is visible the next cycle.
- Read:
  - io_re at cycle N gives io_rdata/io_rvalid at cycle N+1.
  - io_rdata holds its value until the next read.
  - io_rvalid is a single-cycle pulse.
- Simultaneous io_we and io_re: both are performed, and the read returns the pre-write value.
- Input sync: two flops per port, so a change on in_ports is readable at address 4-7 no earlier than 2 cycles later.
- Timer state machine:
  - IDLE (EN=0): COUNT holds.
  - A write to CTRL with EN=1 loads COUNT<=RELOAD and enters RUN. This also applies when already running, which restarts the count.
  - RUN: COUNT decrements by 1 per cycle.
  - Expiry is the cycle COUNT==0 in RUN. It sets pending.
  - On expiry with AUTO=1, COUNT<=RELOAD and stay in RUN, giving period RELOAD+1 cycles.
  - On expiry with AUTO=0, EN clears and the timer goes to IDLE with COUNT=0.
  - A write to CTRL with EN=0 stops immediately; COUNT holds.
  - A RELOAD write during RUN does not disturb COUNT; it takes effect at the next load.
  - RELOAD=0 with AUTO=1 expires every cycle.
- Arithmetic: COUNT is unsigned DATA_W and never decrements below 0 (no wrap).
- Interrupt: tmr_irq=pending.
  - Cleared by irq_ack or by a STATUS bit0 write.
  - Expiry in the same cycle as a clear: set wins, so pending stays 1.
  - A second expiry while pending is already set is not counted.

Decomposition:
- Package io_pkg:
  - address constants A_OUT0..A_OUT3, A_IN0..A_IN3, A_RELOAD, A_CTRL, A_STATUS, A_COUNT.
  - CTRL bit indices CTRL_EN, CTRL_AUTO.
  - timer state enum {IDLE, RUN}.
- Sub-module io_timer contains RELOAD/CTRL/COUNT/pending and the state machine.
- io_unit contains decode, port registers, synchronisers and the read mux.

Test Plan:
- Reset, then write OUT2=0xBEEF (io_addr=2, io_we=1) -> out_ports[47:32]=0xBEEF next cycle; then read addr 2 -> io_rdata=0xBEEF with io_rvalid=1 exactly one cycle after io_re.
- Drive in_ports port1=0x00A5 at cycle N, then read addr 5 at cycles N+1 and N+2 -> N+1 read returns old value 0; N+2 read returns 0x00A5.
- RELOAD=3, CTRL=0b11 -> tmr_irq rises 4 cycles after the CTRL write, COUNT reads back 3 again; after irq_ack, tmr_irq drops and re-asserts 4 cycles after the previous expiry.
- RELOAD=2, CTRL=0b01 (one-shot) -> single expiry after 3 cycles, CTRL reads 0, COUNT stays 0, no further interrupts.
- Assert irq_ack in the exact expiry cycle (RELOAD=0, AUTO=1) -> tmr_irq remains 1.
- Assert reset while the timer is running and a read is pending -> next cycle all outputs 0, io_rvalid=0, COUNT=0, no interrupt.
